parking_gate_arbiter: RTL and testbench

Controller that shares the single barrier gate of the parking lot between the entry and exit requesters. It sits downstream of the two push-button debouncers. It edge-detects their clean outputs, queues one pending request per side, and arbitrates round-robin. It tracks occupancy against capacity and times the gate-open window.

---
 rtl/parking_gate_arbiter.sv | 126 ++++++++++++
 tb/tb_parking_gate_arbiter.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/parking_gate_arbiter.sv
// rtl/parking_gate_arbiter.sv - shares one barrier gate between entry and exit requesters
// Edge-detects debounced buttons, keeps one pending request per side, arbitrates round-robin.
module parking_gate_arbiter #(
  parameter int CAPACITY    = 8,
  parameter int CNT_W       = 4,
  parameter int OPEN_CYCLES = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             entryReq,
  input  logic             exitReq,
  output logic             gateOpen,
  output logic             grantEntry,
  output logic             grantExit,
  output logic             reject,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int TW = (OPEN_CYCLES > 1) ? $clog2(OPEN_CYCLES) : 1;
  localparam logic [TW-1:0]    TLOAD = TW'(OPEN_CYCLES - 1);
  localparam logic [CNT_W-1:0] CAP   = CNT_W'(CAPACITY);

  typedef enum logic [1:0] {IDLE, OPEN, CLOSE} state_t;

  state_t           state, state_nx;
  logic [TW-1:0]    timer, timer_nx;
  logic [CNT_W-1:0] count_nx;
  logic             prev_e, prev_x;
  logic             pend_e, pend_x, pend_e_nx, pend_x_nx;
  logic             last_served, last_nx;
  logic             gate_nx, grant_e_nx, grant_x_nx, reject_nx;
  logic             serve_e, serve_x, ill_e, ill_x;

  assign full  = (count == CAP);
  assign empty = (count == '0);

  always_comb begin
    state_nx   = state;
    timer_nx   = timer;
    count_nx   = count;
    last_nx    = last_served;
    gate_nx    = gateOpen;
    grant_e_nx = 1'b0;
    grant_x_nx = 1'b0;
    reject_nx  = 1'b0;
    serve_e    = 1'b0;
    serve_x    = 1'b0;
    ill_e      = 1'b0;
    ill_x      = 1'b0;
    case (state)
      IDLE: begin
        ill_e = pend_e & full;
        ill_x = pend_x & empty;
        // last_served: 0 = entry, 1 = exit; on a tie the other side wins
        if (pend_e && !full && pend_x && !empty) begin
          serve_x = ~last_served;
          serve_e = last_served;
        end else begin
          serve_e = pend_e & ~full;
          serve_x = pend_x & ~empty;
        end
        reject_nx = ill_e | ill_x;
        if (serve_e || serve_x) begin
          state_nx = OPEN;
          timer_nx = TLOAD;
          gate_nx  = 1'b1;
          last_nx  = serve_x;
        end
        if (serve_e) begin
          grant_e_nx = 1'b1;
          count_nx   = count + 1'b1;
        end
        if (serve_x) begin
          grant_x_nx = 1'b1;
          count_nx   = count - 1'b1;
        end
      end
      OPEN: begin
        if (timer == '0) begin
          gate_nx  = 1'b0;
          state_nx = CLOSE;
        end else begin
          timer_nx = timer - 1'b1;
        end
      end
      CLOSE:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    // a fresh edge in the same cycle as a clear keeps the request pending
    pend_e_nx = (pend_e & ~(serve_e | ill_e)) | (entryReq & ~prev_e);
    pend_x_nx = (pend_x & ~(serve_x | ill_x)) | (exitReq & ~prev_x);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      timer       <= '0;
      count       <= '0;
      prev_e      <= 1'b1;
      prev_x      <= 1'b1;
      pend_e      <= 1'b0;
      pend_x      <= 1'b0;
      last_served <= 1'b0;
      gateOpen    <= 1'b0;
      grantEntry  <= 1'b0;
      grantExit   <= 1'b0;
      reject      <= 1'b0;
    end else begin
      state       <= state_nx;
      timer       <= timer_nx;
      count       <= count_nx;
      prev_e      <= entryReq;
      prev_x      <= exitReq;
      pend_e      <= pend_e_nx;
      pend_x      <= pend_x_nx;
      last_served <= last_nx;
      gateOpen    <= gate_nx;
      grantEntry  <= grant_e_nx;
      grantExit   <= grant_x_nx;
      reject      <= reject_nx;
    end
  end

endmodule

// File: tb/tb_parking_gate_arbiter.sv
// tb/tb_parking_gate_arbiter.sv - scoreboard bench for parking_gate_arbiter
module tb_parking_gate_arbiter;
  localparam int CAP = 2;
  localparam int OC  = 4;
  localparam int CW  = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          entryReq = 1'b0;
  logic          exitReq = 1'b0;
  logic          gateOpen, grantEntry, grantExit, reject, full, empty;
  logic [CW-1:0] count;

  parking_gate_arbiter #(.CAPACITY(CAP), .CNT_W(CW), .OPEN_CYCLES(OC)) dut (
    .clk(clk), .reset(rst_n), .entryReq(entryReq), .exitReq(exitReq),
    .gateOpen(gateOpen), .grantEntry(grantEntry), .grantExit(grantExit),
    .reject(reject), .count(count), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    bit ge;
    bit gx;
    bit rj;
    int cnt;
  } ev_t;

  ev_t sb[$];
  int  n_tests = 0;
  int  n_fail  = 0;

  // reference model: occupancy, one-deep request flags, and a gate busy
  // window of OC open cycles plus one closed guard cycle after each serve
  int cyc = 0;
  bit started = 0;
  bit m_pe, m_px, m_prev_e, m_prev_x, m_last;
  int m_count, idle_at, g_start;
  bit se, sx, ille, illx, le, lx;
  ev_t ev;

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (!rst_n) begin
      started  = 1;
      m_pe     = 0;
      m_px     = 0;
      m_prev_e = 1;
      m_prev_x = 1;
      m_last   = 0;
      m_count  = 0;
      idle_at  = cyc + 1;
      g_start  = -1000;
    end else begin
      se = 0; sx = 0; ille = 0; illx = 0;
      if (cyc >= idle_at) begin
        ille = m_pe && (m_count == CAP);
        illx = m_px && (m_count == 0);
        le = m_pe && !ille;
        lx = m_px && !illx;
        if (le && lx) begin
          if (m_last) se = 1; else sx = 1;
        end else begin
          se = le;
          sx = lx;
        end
        if (ille) m_pe = 0;
        if (illx) m_px = 0;
        if (se) begin m_pe = 0; m_count = m_count + 1; m_last = 0; end
        if (sx) begin m_px = 0; m_count = m_count - 1; m_last = 1; end
        if (se || sx) begin
          idle_at = cyc + OC + 2;
          g_start = cyc;
        end
        if (se || sx || ille || illx) begin
          ev.cyc = cyc; ev.ge = se; ev.gx = sx; ev.rj = ille || illx; ev.cnt = m_count;
          sb.push_back(ev);
        end
      end
      if (entryReq && !m_prev_e) m_pe = 1;
      if (exitReq && !m_prev_x) m_px = 1;
      m_prev_e = entryReq;
      m_prev_x = exitReq;
    end
  end

  bit  final_chk = 0;
  bit  final_done = 0;
  ev_t e;
  bit  m_gate;

  always @(negedge clk) begin
    if (started) begin
      if (grantEntry || grantExit || reject) begin
        n_tests = n_tests + 1;
        if (sb.size() == 0) begin
          n_fail = n_fail + 1;
          $display("FAIL unexpected_pulse cyc=%0d got ge=%b gx=%b rj=%b required none",
                   cyc, grantEntry, grantExit, reject);
        end else begin
          e = sb.pop_front();
          if (e.cyc != cyc || e.ge != grantEntry || e.gx != grantExit || e.rj != reject ||
              e.cnt != int'(count)) begin
            n_fail = n_fail + 1;
            $display("FAIL event cyc=%0d got ge=%b gx=%b rj=%b count=%0d required cyc=%0d ge=%b gx=%b rj=%b count=%0d",
                     cyc, grantEntry, grantExit, reject, count, e.cyc, e.ge, e.gx, e.rj, e.cnt);
          end
        end
      end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
        n_tests = n_tests + 1;
        n_fail  = n_fail + 1;
        e = sb.pop_front();
        $display("FAIL missing_event cyc=%0d got no pulse required ge=%b gx=%b rj=%b at cyc=%0d",
                 cyc, e.ge, e.gx, e.rj, e.cyc);
      end
      m_gate = (cyc >= g_start) && (cyc < g_start + OC);
      n_tests = n_tests + 1;
      if (gateOpen !== m_gate || int'(count) != m_count || full !== (m_count == CAP) ||
          empty !== (m_count == 0)) begin
        n_fail = n_fail + 1;
        $display("FAIL levels cyc=%0d got gate=%b count=%0d full=%b empty=%b required gate=%b count=%0d full=%b empty=%b",
                 cyc, gateOpen, count, full, empty, m_gate, m_count, m_count == CAP, m_count == 0);
      end
      if (final_chk && !final_done) begin
        final_done = 1;
        n_tests = n_tests + 1;
        if (sb.size() != 0) begin
          n_fail = n_fail + 1;
          $display("FAIL drain got %0d outstanding events required 0", sb.size());
        end
      end
    end
  end

  task automatic step(input bit r, input bit en, input bit ex);
    @(negedge clk);
    rst_n = r; entryReq = en; exitReq = ex;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1, 0, 0);
  endtask

  task automatic press(input bit en, input bit ex, input int hold);
    repeat (hold) step(1, en, ex);
    step(1, 0, 0);
  endtask

  bit re, rx;

  initial begin
    repeat (2) @(posedge clk);
    idle(4);
    press(1, 0, 2);                  // single entry
    idle(10);
    press(1, 1, 2);                  // simultaneous, count=1
    idle(16);
    press(1, 0, 1); idle(8);         // fill to capacity
    press(1, 0, 1); idle(4);         // rejected at full
    press(0, 1, 1); idle(8);
    press(0, 1, 1); idle(8);
    press(0, 1, 1); idle(4);         // rejected at empty
    press(1, 0, 1);                  // presses merged during OPEN
    press(1, 0, 1); press(1, 0, 1); press(1, 0, 1);
    idle(16);
    press(0, 1, 1); idle(8);
    press(0, 1, 1); idle(8);
    step(1, 1, 0); step(1, 1, 0); step(1, 1, 0);   // reset during OPEN, button held
    step(0, 1, 0);
    repeat (5) step(1, 1, 0);
    idle(3);
    press(1, 0, 1);
    idle(10);
    re = 0; rx = 0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 3) == 0) re = ~re;
      if ($urandom_range(0, 3) == 0) rx = ~rx;
      step(($urandom_range(0, 199) != 0), re, rx);
    end
    idle(20);
    final_chk = 1;
    @(negedge clk);
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
